div_share_arbiter: RTL and testbench

- Shares one non-restoring divider core (8-bit in_bus / begin_div / fin / out_bus protocol) between NREQ independent requesters.
- Arbitrates round-robin and serialises the winner's 16-bit dividend and 8-bit divisor onto the divider's byte bus.
- Collects remainder and quotient from the divider's output bus and returns them with the requester ID.
- Sits between client blocks and the divider top; the divider's internal control unit is untouched.

---
 rtl/div_arb_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 42 ++++
 rtl/div_share_arbiter.sv | 164 ++++++++++++++++
 tb/tb_div_share_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_arb_pkg.sv
// Shared widths, FSM state codes and response constants for the divider-sharing arbiter.
package div_arb_pkg;

   localparam int DIVIDEND_W = 16;
   localparam int DIVISOR_W  = 8;
   localparam int BUS_W      = 8;

   typedef logic [2:0] state_t;

   localparam state_t S_IDLE  = 3'd0;
   localparam state_t S_LD_HI = 3'd1;
   localparam state_t S_LD_LO = 3'd2;
   localparam state_t S_LD_M  = 3'd3;
   localparam state_t S_WAIT  = 3'd4;
   localparam state_t S_RD_Q  = 3'd5;
   localparam state_t S_RESP  = 3'd6;
   localparam state_t S_ABORT = 3'd7;

   localparam logic             ERR_NONE   = 1'b0;
   localparam logic             ERR_SET    = 1'b1;
   localparam logic [BUS_W-1:0] ABORT_QUOT = 8'h00;
   localparam logic [BUS_W-1:0] ABORT_REM  = 8'h00;
   localparam logic [BUS_W-1:0] DZ_QUOT    = 8'hFF;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping at NREQ.
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   input  logic            en,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  idx,
   output logic            found
);

   logic [IDW-1:0] cand [NREQ];

   // cand[k] = (ptr + k) mod NREQ, computed one bit wider so the wrap test cannot overflow
   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_cand
         logic [IDW:0] sum;
         assign sum      = {1'b0, ptr} + (IDW+1)'(gi);
         assign cand[gi] = (sum >= (IDW+1)'(NREQ)) ? IDW'(sum - (IDW+1)'(NREQ)) : sum[IDW-1:0];
      end
   endgenerate

   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      // scanning from the far end lets the nearest candidate overwrite the rest
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (en && req[cand[k]]) begin
            found = 1'b1;
            idx   = cand[k];
         end
      end
      if (found) begin
         grant[idx] = 1'b1;
      end
   end

endmodule

// File: rtl/div_share_arbiter.sv
// Round-robin front end sharing one byte-bus divider among NREQ clients.
// Optional DIV_ZERO_CHK_EN answers zero-divisor jobs locally without starting the divider.
module div_share_arbiter
   import div_arb_pkg::*;
#(
   parameter int NREQ        = 4,
   parameter int IDW         = 2,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NREQ-1:0]            req_valid,
   output logic [NREQ-1:0]            req_ready,
   input  logic [DIVIDEND_W*NREQ-1:0] req_dividend,
   input  logic [DIVISOR_W*NREQ-1:0]  req_divisor,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [IDW-1:0]             rsp_id,
   output logic [BUS_W-1:0]           rsp_quot,
   output logic [BUS_W-1:0]           rsp_rem,
   output logic                       rsp_err,
   output logic [BUS_W-1:0]           div_in_bus,
   output logic                       div_begin,
   output logic                       div_rst,
   input  logic                       div_fin,
   input  logic [BUS_W-1:0]           div_out_bus
);

   localparam int               CNT_W    = $clog2(TIMEOUT_CYC) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   state_t                state_reg;
   logic [IDW-1:0]        ptr_reg;
   logic [IDW-1:0]        id_reg;
   logic [DIVIDEND_W-1:0] dividend_reg;
   logic [DIVISOR_W-1:0]  divisor_reg;
   logic [CNT_W-1:0]      cnt_reg;
   logic [BUS_W-1:0]      quot_reg;
   logic [BUS_W-1:0]      rem_reg;
   logic                  err_reg;

   logic [NREQ-1:0]       grant;
   logic [IDW-1:0]        grant_idx;
   logic                  grant_found;
   logic                  arb_en;
   logic [IDW-1:0]        ptr_next;

   logic [DIVIDEND_W-1:0] dividend_arr [NREQ];
   logic [DIVISOR_W-1:0]  divisor_arr  [NREQ];

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_unpack
         assign dividend_arr[gi] = req_dividend[DIVIDEND_W*gi +: DIVIDEND_W];
         assign divisor_arr[gi]  = req_divisor[DIVISOR_W*gi +: DIVISOR_W];
      end
   endgenerate

   // grants only come out of IDLE, never while reset is held
   assign arb_en = (state_reg == S_IDLE) && !rst;

   rr_arbiter #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_rr (
      .req   (req_valid),
      .ptr   (ptr_reg),
      .en    (arb_en),
      .grant (grant),
      .idx   (grant_idx),
      .found (grant_found)
   );

   assign ptr_next = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= S_IDLE;
         ptr_reg      <= '0;
         id_reg       <= '0;
         dividend_reg <= '0;
         divisor_reg  <= '0;
         cnt_reg      <= '0;
         quot_reg     <= '0;
         rem_reg      <= '0;
         err_reg      <= ERR_NONE;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (grant_found) begin
                  id_reg       <= grant_idx;
                  dividend_reg <= dividend_arr[grant_idx];
                  divisor_reg  <= divisor_arr[grant_idx];
                  ptr_reg      <= ptr_next;
                  state_reg    <= S_LD_HI;
`ifdef DIV_ZERO_CHK_EN
                  if (divisor_arr[grant_idx] == '0) begin
                     quot_reg  <= DZ_QUOT;
                     rem_reg   <= dividend_arr[grant_idx][BUS_W-1:0];
                     err_reg   <= ERR_SET;
                     state_reg <= S_RESP;
                  end
`endif
               end
            end
            S_LD_HI: state_reg <= S_LD_LO;
            S_LD_LO: state_reg <= S_LD_M;
            S_LD_M:  state_reg <= S_WAIT;
            S_WAIT: begin
               cnt_reg <= cnt_reg + 1'b1;
               // a finish on the last allowed cycle still wins over the timeout
               if (div_fin) begin
                  rem_reg   <= div_out_bus;
                  state_reg <= S_RD_Q;
               end else if (cnt_reg == CNT_LAST) begin
                  state_reg <= S_ABORT;
               end
            end
            S_RD_Q: begin
               if (div_fin) begin
                  quot_reg  <= div_out_bus;
                  state_reg <= S_RESP;
               end else begin
                  state_reg <= S_ABORT;
               end
            end
            S_ABORT: begin
               quot_reg  <= ABORT_QUOT;
               rem_reg   <= ABORT_REM;
               err_reg   <= ERR_SET;
               state_reg <= S_RESP;
            end
            S_RESP: begin
               if (rsp_ready) begin
                  err_reg   <= ERR_NONE;
                  cnt_reg   <= '0;
                  state_reg <= S_IDLE;
               end
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      div_in_bus = '0;
      case (state_reg)
         S_LD_HI: div_in_bus = dividend_reg[DIVIDEND_W-1 -: BUS_W];
         S_LD_LO: div_in_bus = dividend_reg[BUS_W-1:0];
         S_LD_M:  div_in_bus = divisor_reg;
         default: div_in_bus = '0;
      endcase
   end

   assign req_ready = grant;
   assign div_begin = (state_reg == S_LD_HI);
   assign div_rst   = rst | (state_reg == S_ABORT);
   assign rsp_valid = (state_reg == S_RESP);
   assign rsp_id    = id_reg;
   assign rsp_quot  = quot_reg;
   assign rsp_rem   = rem_reg;
   assign rsp_err   = err_reg;

endmodule

// File: tb/tb_div_share_arbiter.sv
// Directed-vector bench for div_share_arbiter with a behavioural byte-bus divider stand-in.
module tb_div_share_arbiter;

   localparam int NREQ    = 4;
   localparam int IDW     = 2;
   localparam int TIMEOUT = 64;

   localparam int M_NORM  = 0;
   localparam int M_NEVER = 1;
   localparam int M_ONE   = 2;
   localparam int M_DZ    = 3;

   typedef struct packed {
      logic [3:0]  valid;
      logic [15:0] dvd;
      logic [7:0]  dvs;
      int          mode;
      int          lat;
      int          hold;
      int          id;
      logic [7:0]  q;
      logic [7:0]  r;
      logic        err;
   } vec_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [NREQ-1:0]  req_valid = '0;
   logic [NREQ-1:0]  req_ready;
   logic [16*NREQ-1:0] req_dividend = '0;
   logic [8*NREQ-1:0]  req_divisor = '0;
   logic             rsp_valid;
   logic             rsp_ready = 1'b0;
   logic [IDW-1:0]   rsp_id;
   logic [7:0]       rsp_quot;
   logic [7:0]       rsp_rem;
   logic             rsp_err;
   logic [7:0]       div_in_bus;
   logic             div_begin;
   logic             div_rst;
   logic             div_fin;
   logic [7:0]       div_out_bus;

   int checks = 0;
   int errors = 0;

   div_share_arbiter #(
      .NREQ        (NREQ),
      .IDW         (IDW),
      .TIMEOUT_CYC (TIMEOUT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_dividend (req_dividend),
      .req_divisor  (req_divisor),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_id       (rsp_id),
      .rsp_quot     (rsp_quot),
      .rsp_rem      (rsp_rem),
      .rsp_err      (rsp_err),
      .div_in_bus   (div_in_bus),
      .div_begin    (div_begin),
      .div_rst      (div_rst),
      .div_fin      (div_fin),
      .div_out_bus  (div_out_bus)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog expired actual=running required=finished");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Divider stand-in: loads three bytes after div_begin, then raises fin with rem, then quot.
   int          m_mode = M_NORM;
   int          m_lat = 1;
   int          m_ph = 0;
   int          m_cnt = 0;
   int          m_begins = 0;
   logic [7:0]  m_hi, m_lo, m_dvs, m_q, m_r;
   logic [15:0] d16;

   initial begin
      div_fin     = 1'b0;
      div_out_bus = 8'h00;
      forever begin
         @(negedge clk);
         if (div_rst) begin
            m_ph        = 0;
            div_fin     = 1'b0;
            div_out_bus = 8'h00;
         end else begin
            case (m_ph)
               0: if (div_begin) begin
                  m_begins++;
                  m_hi = div_in_bus;
                  m_ph = 1;
               end
               1: begin
                  m_lo = div_in_bus;
                  m_ph = 2;
               end
               2: begin
                  m_dvs = div_in_bus;
                  d16   = {m_hi, m_lo};
                  if (m_dvs == 8'h00) begin
                     m_q = 8'hFF;
                     m_r = m_lo;
                  end else begin
                     m_q = 8'(d16 / {8'h00, m_dvs});
                     m_r = 8'(d16 % {8'h00, m_dvs});
                  end
                  m_cnt = 0;
                  m_ph  = 3;
               end
               3: if (m_mode != M_NEVER) begin
                  m_cnt++;
                  if (m_cnt >= m_lat) begin
                     div_fin     = 1'b1;
                     div_out_bus = m_r;
                     m_ph        = 4;
                  end
               end
               4: begin
                  if (m_mode == M_ONE) begin
                     div_fin     = 1'b0;
                     div_out_bus = 8'h00;
                     m_ph        = 0;
                  end else begin
                     div_out_bus = m_q;
                     m_ph        = 5;
                  end
               end
               5: begin
                  div_fin     = 1'b0;
                  div_out_bus = 8'h00;
                  m_ph        = 0;
               end
               default: m_ph = 0;
            endcase
         end
      end
   end

   function automatic vec_t mk(input logic [3:0] valid, input logic [15:0] dvd, input logic [7:0] dvs,
                               input int mode, input int lat, input int hold, input int id,
                               input logic [7:0] q, input logic [7:0] r, input logic err);
      vec_t v;
      v.valid = valid; v.dvd = dvd; v.dvs = dvs; v.mode = mode; v.lat = lat;
      v.hold = hold; v.id = id; v.q = q; v.r = r; v.err = err;
      return v;
   endfunction

   task automatic run_vec(input int n, input vec_t v);
      int   lat;
      int   rst_pulses;
      int   begins0;
      int   exp_lat;
      int   exp_pulses;
      int   exp_begins;
      logic exp_err;
      bit   skip;
      skip    = 1'b0;
      exp_err = v.err;
`ifdef DIV_ZERO_CHK_EN
      if (v.mode == M_DZ) begin
         skip    = 1'b1;
         exp_err = 1'b1;
      end
`endif
      case (v.mode)
         M_NEVER: exp_lat = TIMEOUT + 5;
         M_ONE:   exp_lat = 6 + v.lat;
         default: exp_lat = 5 + v.lat;
      endcase
      if (skip) exp_lat = 1;
      exp_pulses = (v.mode == M_NEVER || v.mode == M_ONE) ? 1 : 0;
      exp_begins = skip ? 0 : 1;

      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
         req_dividend[16*i +: 16] = 16'hA050 + 16'(i);
         req_divisor[8*i +: 8]    = 8'h03 + 8'(i);
      end
      req_dividend[16*v.id +: 16] = v.dvd;
      req_divisor[8*v.id +: 8]    = v.dvs;
      m_mode     = v.mode;
      m_lat      = v.lat;
      begins0    = m_begins;
      rst_pulses = 0;
      req_valid  = v.valid;
      #1;
      check("grant", 32'(req_ready), 32'(1) << v.id);

      @(negedge clk);
      lat = 1;
      check("grant_pulse", 32'(req_ready), 32'(0));
      req_valid = '0;
      if (!skip) begin
         check("ld_hi", 32'({div_begin, div_in_bus}), 32'({1'b1, v.dvd[15:8]}));
         @(negedge clk); lat++;
         check("ld_lo", 32'({div_begin, div_in_bus}), 32'({1'b0, v.dvd[7:0]}));
         @(negedge clk); lat++;
         check("ld_m", 32'({div_begin, div_in_bus}), 32'({1'b0, v.dvs}));
         @(negedge clk); lat++;
         check("bus_idle", 32'({div_begin, div_in_bus}), 32'(0));
      end
      while (!rsp_valid && lat < 300) begin
         if (div_rst) rst_pulses++;
         @(negedge clk);
         lat++;
      end
      check("rsp_valid", 32'(rsp_valid), 32'(1));
      check("latency", 32'(lat), 32'(exp_lat));
      check("rsp_id", 32'(rsp_id), 32'(v.id));
      check("rsp_quot", 32'(rsp_quot), 32'(v.q));
      check("rsp_rem", 32'(rsp_rem), 32'(v.r));
      check("rsp_err", 32'(rsp_err), 32'(exp_err));
      check("div_rst_pulses", 32'(rst_pulses), 32'(exp_pulses));
      check("div_begin_count", 32'(m_begins - begins0), 32'(exp_begins));
      $display("vec %0d id=%0d quot=%02h rem=%02h err=%0b lat=%0d", n, rsp_id, rsp_quot, rsp_rem, rsp_err, lat);

      if (v.hold > 0) begin
         req_valid = '1;
         for (int h = 0; h < v.hold; h++) begin
            #1;
            check("hold_rsp", 32'({rsp_valid, rsp_id, rsp_quot, rsp_rem, rsp_err}),
                  32'({1'b1, 2'(v.id), v.q, v.r, exp_err}));
            check("hold_no_grant", 32'(req_ready), 32'(0));
            @(negedge clk);
         end
         req_valid = '0;
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check("rsp_release", 32'({rsp_valid, rsp_err}), 32'(0));
   endtask

   vec_t vecs [14];
   int   seen;

   initial begin
      vecs[0]  = mk(4'b0001, 16'h0064, 8'h07, M_NORM,  1,  0, 0, 8'h0E, 8'h02, 1'b0);
      vecs[1]  = mk(4'b1111, 16'h03E8, 8'h09, M_NORM,  2,  0, 1, 8'h6F, 8'h01, 1'b0);
      vecs[2]  = mk(4'b1111, 16'h00FF, 8'h10, M_NORM,  1,  0, 2, 8'h0F, 8'h0F, 1'b0);
      vecs[3]  = mk(4'b1111, 16'h1234, 8'hC8, M_NORM,  4,  0, 3, 8'h17, 8'h3C, 1'b0);
      vecs[4]  = mk(4'b1111, 16'h0FA0, 8'h20, M_NORM,  1,  0, 0, 8'h7D, 8'h00, 1'b0);
      vecs[5]  = mk(4'b1111, 16'h00C8, 8'h0D, M_NORM,  3,  0, 1, 8'h0F, 8'h05, 1'b0);
      vecs[6]  = mk(4'b1111, 16'h7F80, 8'h80, M_NORM,  1,  0, 2, 8'hFF, 8'h00, 1'b0);
      vecs[7]  = mk(4'b1111, 16'h0005, 8'h09, M_NORM,  2,  0, 3, 8'h00, 8'h05, 1'b0);
      vecs[8]  = mk(4'b0101, 16'h1111, 8'h22, M_NEVER, 1,  0, 0, 8'h00, 8'h00, 1'b1);
      vecs[9]  = mk(4'b0101, 16'h0100, 8'h10, M_NORM,  1,  0, 2, 8'h10, 8'h00, 1'b0);
      vecs[10] = mk(4'b0001, 16'h0050, 8'h05, M_ONE,   2,  0, 0, 8'h00, 8'h00, 1'b1);
      vecs[11] = mk(4'b1000, 16'h0063, 8'h0A, M_NORM,  1, 10, 3, 8'h09, 8'h09, 1'b0);
      vecs[12] = mk(4'b0010, 16'hABCD, 8'h00, M_DZ,    1,  0, 1, 8'hFF, 8'hCD, 1'b0);
      vecs[13] = mk(4'b0110, 16'h0200, 8'h03, M_NORM, 64,  0, 2, 8'hAA, 8'h02, 1'b0);

      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check("reset_req_ready", 32'(req_ready), 32'(0));
      check("reset_rsp", 32'({rsp_valid, rsp_id, rsp_quot, rsp_rem, rsp_err}), 32'(0));
      check("reset_div", 32'({div_begin, div_rst, div_in_bus}), 32'(0));

      for (int n = 0; n < 14; n++) begin
         run_vec(n, vecs[n]);
      end

      // reset while the divider is being waited on
      @(negedge clk);
      m_mode = M_NEVER;
      m_lat  = 1;
      req_dividend[16*2 +: 16] = 16'h4321;
      req_divisor[8*2 +: 8]    = 8'h11;
      req_valid = 4'b0100;
      #1;
      check("rstseq_grant", 32'(req_ready), 32'(4'b0100));
      @(negedge clk);
      req_valid = '0;
      repeat (3) @(negedge clk);
      check("rstseq_in_wait", 32'({rsp_valid, div_begin, div_in_bus}), 32'(0));
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rstseq_div_rst", 32'(div_rst), 32'(1));
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rstseq_outputs", 32'({req_ready, rsp_valid, rsp_id, rsp_quot, rsp_rem, rsp_err,
                                   div_in_bus, div_begin, div_rst}), 32'(0));
      seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (rsp_valid || (req_ready != '0)) seen++;
      end
      check("rstseq_no_rsp", 32'(seen), 32'(0));
      $display("rst_seq seen=%0d", seen);
      run_vec(14, mk(4'b1111, 16'h0064, 8'h07, M_NORM, 1, 0, 0, 8'h0E, 8'h02, 1'b0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
